// File: rtl/padctrl_attr_seq.sv
// padctrl_attr_seq: pad-attribute update sequencer.
// Arbitrates software and hardware attribute writes round-robin, applies the
// WARL mask, issues one pad write at a time and then holds off further grants
// for a settle window so drive/pull changes on different pads never coincide.
// Optional build macro: PADCTRL_ATTR_SEQ_SHADOW_EN keeps a per-pad shadow of the
// last written value and skips writes (and their settle window) that would not
// change the pad.
module padctrl_attr_seq #(
    parameter int NPads        = 20,
    parameter int AttrDw       = 8,
    parameter int SettleCycles = 4,
    parameter int IdxW         = $clog2(NPads)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sw_req_i,
    input  logic [IdxW-1:0]   sw_idx_i,
    input  logic [AttrDw-1:0] sw_attr_i,
    output logic              sw_gnt_o,
    input  logic              hw_req_i,
    input  logic [IdxW-1:0]   hw_idx_i,
    input  logic [AttrDw-1:0] hw_attr_i,
    output logic              hw_gnt_o,
    input  logic [AttrDw-1:0] warl_mask_i,
    output logic              attr_we_o,
    output logic [IdxW-1:0]   attr_idx_o,
    output logic [AttrDw-1:0] attr_o,
    output logic              busy_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StApply  = 2'd1,
        StSettle = 2'd2
    } state_e;

    // Counter only needs to hold SettleCycles-1; keep at least one bit so a
    // zero-length settle window still elaborates cleanly.
    localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'((SettleCycles > 0) ? (SettleCycles - 1) : 0);
    // One extra bit so the range check also works when NPads is a power of two.
    localparam logic [IdxW:0] IdxLimit = (IdxW + 1)'(NPads);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_hw_q, last_hw_d;
    logic [IdxW-1:0]   cap_idx_q, cap_idx_d;
    logic [AttrDw-1:0] cap_attr_q, cap_attr_d;
    logic              we_q, we_d;
    logic [IdxW-1:0]   idx_out_q, idx_out_d;
    logic [AttrDw-1:0] attr_out_q, attr_out_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              sw_win;
    logic              hw_win;
    logic              can_grant;
    logic              any_gnt;
    logic [IdxW-1:0]   sel_idx;
    logic [AttrDw-1:0] sel_attr;
    logic              sel_idx_bad;
    logic [AttrDw-1:0] masked_attr;
    logic              shadow_hit;

    // Round-robin pick: a lone requester wins; on contention the side that was
    // not granted last wins.
    always_comb begin
        sw_win      = sw_req_i & (~hw_req_i | last_hw_q);
        hw_win      = hw_req_i & ~sw_win;
        sel_idx     = sw_win ? sw_idx_i : hw_idx_i;
        sel_attr    = sw_win ? sw_attr_i : hw_attr_i;
        sel_idx_bad = ({1'b0, sel_idx} >= IdxLimit);
    end

    // Grants are combinational in IDLE; held low while reset is asserted so the
    // outputs read zero during reset even if requests are pending.
    assign can_grant = (state_q == StIdle) & rst_ni;
    assign sw_gnt_o  = can_grant & sw_win;
    assign hw_gnt_o  = can_grant & hw_win;
    assign any_gnt   = sw_gnt_o | hw_gnt_o;

    // The mask is applied in the APPLY cycle, so it reflects the mask at write time.
    assign masked_attr = cap_attr_q & warl_mask_i;

`ifdef PADCTRL_ATTR_SEQ_SHADOW_EN
    logic [AttrDw-1:0] shadow_q [NPads];
    logic [AttrDw-1:0] shadow_d [NPads];

    assign shadow_hit = we_q & (shadow_q[cap_idx_q] == masked_attr);

    // Shadow next-value: record the masked value of every real write.
    always_comb begin
        shadow_d = shadow_q;
        if (attr_we_o) begin
            shadow_d[cap_idx_q] = masked_attr;
        end
    end

    // Shadow storage, cleared on reset to match the reset state of the pads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NPads; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    assign shadow_hit = 1'b0;
`endif

    assign attr_we_o  = we_q & ~shadow_hit;
    assign attr_idx_o = idx_out_q;
    assign attr_o     = attr_we_o ? masked_attr : attr_out_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

    // FSM next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_hw_d  = last_hw_q;
        cap_idx_d  = cap_idx_q;
        cap_attr_d = cap_attr_q;
        we_d       = 1'b0;
        idx_out_d  = idx_out_q;
        attr_out_d = attr_out_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_gnt) begin
                    last_hw_d  = hw_win;
                    cap_idx_d  = sel_idx;
                    cap_attr_d = sel_attr;
                    if (sel_idx_bad) begin
                        // Bad index: flag it, write nothing, stay ready for the next grant.
                        err_d = 1'b1;
                    end else begin
                        state_d   = StApply;
                        we_d      = 1'b1;
                        idx_out_d = sel_idx;
                    end
                end
            end
            StApply: begin
                if (attr_we_o) begin
                    attr_out_d = masked_attr;
                end
                if (shadow_hit || (SettleCycles == 0)) begin
                    state_d = StIdle;
                end else begin
                    state_d = StSettle;
                    cnt_d   = CntLoad;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset aborts any write in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_hw_q  <= 1'b1;
            cap_idx_q  <= '0;
            cap_attr_q <= '0;
            we_q       <= 1'b0;
            idx_out_q  <= '0;
            attr_out_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_hw_q  <= last_hw_d;
            cap_idx_q  <= cap_idx_d;
            cap_attr_q <= cap_attr_d;
            we_q       <= we_d;
            idx_out_q  <= idx_out_d;
            attr_out_q <= attr_out_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_padctrl_attr_seq.sv
// Directed bench for padctrl_attr_seq: one instance with a 4-cycle settle
// window and one with no settle window. Expected writes are queued when a
// request is driven and matched against each observed write strobe.
module tb_padctrl_attr_seq;

    localparam int NPads  = 20;
    localparam int AttrDw = 8;
    localparam int IdxW   = 5;

    logic              clk;
    logic              rst_n;
    logic [AttrDw-1:0] mask;

    logic              sw_req, hw_req, sw_gnt, hw_gnt;
    logic [IdxW-1:0]   sw_idx, hw_idx, attr_idx;
    logic [AttrDw-1:0] sw_attr, hw_attr, attr_val;
    logic              we, busy, err;

    logic              sw0_req, hw0_req, sw0_gnt, hw0_gnt;
    logic [IdxW-1:0]   sw0_idx, hw0_idx, attr0_idx;
    logic [AttrDw-1:0] sw0_attr, hw0_attr, attr0_val;
    logic              we0, busy0, err0;

    int checks = 0;
    int errors = 0;

    logic [IdxW+AttrDw-1:0] exp_q[$];
    logic [IdxW+AttrDw-1:0] exp0_q[$];

    padctrl_attr_seq #(.NPads(NPads), .AttrDw(AttrDw), .SettleCycles(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .sw_req_i(sw_req), .sw_idx_i(sw_idx), .sw_attr_i(sw_attr), .sw_gnt_o(sw_gnt),
        .hw_req_i(hw_req), .hw_idx_i(hw_idx), .hw_attr_i(hw_attr), .hw_gnt_o(hw_gnt),
        .warl_mask_i(mask), .attr_we_o(we), .attr_idx_o(attr_idx), .attr_o(attr_val),
        .busy_o(busy), .err_o(err)
    );

    padctrl_attr_seq #(.NPads(NPads), .AttrDw(AttrDw), .SettleCycles(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .sw_req_i(sw0_req), .sw_idx_i(sw0_idx), .sw_attr_i(sw0_attr), .sw_gnt_o(sw0_gnt),
        .hw_req_i(hw0_req), .hw_idx_i(hw0_idx), .hw_attr_i(hw0_attr), .hw_gnt_o(hw0_gnt),
        .warl_mask_i(mask), .attr_we_o(we0), .attr_idx_o(attr0_idx), .attr_o(attr0_val),
        .busy_o(busy0), .err_o(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IdxW-1:0] idx, input logic [AttrDw-1:0] a);
        exp_q.push_back({idx, a});
    endtask

    task automatic push0(input logic [IdxW-1:0] idx, input logic [AttrDw-1:0] a);
        exp0_q.push_back({idx, a});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk1("idle_bound", (n < 40), 1'b1);
    endtask

    // Scoreboard: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk1("unexpected_we", we, 1'b0);
            end else begin
                logic [IdxW+AttrDw-1:0] e;
                e = exp_q.pop_front();
                chk("wr_idx", 32'(attr_idx), 32'(e[IdxW+AttrDw-1:AttrDw]));
                chk("wr_attr", 32'(attr_val), 32'(e[AttrDw-1:0]));
            end
        end
        if (we0 === 1'b1) begin
            if (exp0_q.size() == 0) begin
                chk1("unexpected_we0", we0, 1'b0);
            end else begin
                logic [IdxW+AttrDw-1:0] e0;
                e0 = exp0_q.pop_front();
                chk("wr0_idx", 32'(attr0_idx), 32'(e0[IdxW+AttrDw-1:AttrDw]));
                chk("wr0_attr", 32'(attr0_val), 32'(e0[AttrDw-1:0]));
            end
        end
    end

    initial begin
        rst_n = 1'b0; mask = 8'h3F;
        sw_req = 1'b0; sw_idx = '0; sw_attr = '0;
        hw_req = 1'b0; hw_idx = '0; hw_attr = '0;
        sw0_req = 1'b0; sw0_idx = '0; sw0_attr = '0;
        hw0_req = 1'b0; hw0_idx = '0; hw0_attr = '0;
        repeat (2) tick();
        #1;
        chk1("rst_sw_gnt", sw_gnt, 1'b0);
        chk1("rst_hw_gnt", hw_gnt, 1'b0);
        chk1("rst_we", we, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_idx", 32'(attr_idx), 32'd0);
        chk("rst_attr", 32'(attr_val), 32'd0);
        rst_n = 1'b1;

        // Single software write with settle window of 4.
        tick(); sw_req = 1'b1; sw_idx = 5'd3; sw_attr = 8'hFF; #1;
        chk1("t1_sw_gnt", sw_gnt, 1'b1);
        chk1("t1_hw_gnt", hw_gnt, 1'b0);
        push(5'd3, 8'h3F);
        tick(); sw_req = 1'b0; #1;
        chk1("t1_we", we, 1'b1);
        chk1("t1_busy_apply", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); sw_req = 1'b1; sw_idx = 5'd7; sw_attr = 8'h41; #1;
            chk1("t1_busy_settle", busy, 1'b1);
            chk1("t1_no_gnt_settle", sw_gnt, 1'b0);
            chk1("t1_no_we_settle", we, 1'b0);
        end
        tick(); #1;
        chk1("t1_busy_done", busy, 1'b0);
        chk1("t1_regrant", sw_gnt, 1'b1);
        push(5'd7, 8'h01);
        tick(); sw_req = 1'b0; #1;
        chk1("t1_we2", we, 1'b1);
        wait_idle();

        // Contention from reset: alternating sw/hw, 6 cycles apart.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        sw_req = 1'b1; sw_idx = 5'd1; sw_attr = 8'h11;
        hw_req = 1'b1; hw_idx = 5'd2; hw_attr = 8'h22; #1;
        for (int k = 0; k < 4; k++) begin
            chk1("fair_sw_gnt", sw_gnt, (k % 2 == 0));
            chk1("fair_hw_gnt", hw_gnt, (k % 2 != 0));
            if (k % 2 == 0) push(5'd1, 8'h11); else push(5'd2, 8'h22);
            if (k < 3) begin
                for (int j = 0; j < 5; j++) begin
                    tick(); #1;
                    chk1("fair_gap_gnt", sw_gnt | hw_gnt, 1'b0);
                end
                tick(); #1;
            end
        end
        tick(); sw_req = 1'b0; hw_req = 1'b0;
        wait_idle();

        // Out-of-range hw index, then sw granted the next cycle; mask changes at APPLY.
        tick(); hw_req = 1'b1; hw_idx = 5'd20; hw_attr = 8'h55; #1;
        chk1("oor_hw_gnt", hw_gnt, 1'b1);
        tick(); hw_req = 1'b0; sw_req = 1'b1; sw_idx = 5'd9; sw_attr = 8'h3E; #1;
        chk1("oor_err", err, 1'b1);
        chk1("oor_no_we", we, 1'b0);
        chk1("oor_busy", busy, 1'b0);
        chk("oor_idx_hold", 32'(attr_idx), 32'd2);
        chk1("oor_next_sw_gnt", sw_gnt, 1'b1);
        push(5'd9, 8'h02);
        tick(); sw_req = 1'b0; mask = 8'h03; #1;
        chk1("oor_err_single", err, 1'b0);
        chk1("oor_we", we, 1'b1);
        tick(); mask = 8'h3F;
        wait_idle();

        // Reset two cycles after a write, with both requesters pending.
        tick(); sw_req = 1'b1; sw_idx = 5'd4; sw_attr = 8'h0A; #1;
        chk1("rms_gnt", sw_gnt, 1'b1);
        push(5'd4, 8'h0A);
        tick(); sw_req = 1'b0; #1;
        chk1("rms_we", we, 1'b1);
        tick(); tick();
        rst_n = 1'b0;
        sw_req = 1'b1; sw_idx = 5'd8; sw_attr = 8'h07;
        hw_req = 1'b1; hw_idx = 5'd6; hw_attr = 8'h30; #1;
        chk1("rms_busy", busy, 1'b0);
        chk1("rms_we0", we, 1'b0);
        chk("rms_idx", 32'(attr_idx), 32'd0);
        chk("rms_attr", 32'(attr_val), 32'd0);
        chk1("rms_sw_gnt", sw_gnt, 1'b0);
        chk1("rms_hw_gnt", hw_gnt, 1'b0);
        tick(); rst_n = 1'b1; #1;
        chk1("rms_post_sw_gnt", sw_gnt, 1'b1);
        chk1("rms_post_hw_gnt", hw_gnt, 1'b0);
        push(5'd8, 8'h07);
        tick(); sw_req = 1'b0; hw_req = 1'b0; #1;
        chk1("rms_post_we", we, 1'b1);
        wait_idle();

        // Same value to the same pad twice.
        tick(); sw_req = 1'b1; sw_idx = 5'd5; sw_attr = 8'h12; #1;
        chk1("dup1_gnt", sw_gnt, 1'b1);
        push(5'd5, 8'h12);
        tick(); sw_req = 1'b0; #1;
        chk1("dup1_we", we, 1'b1);
        wait_idle();
        tick(); sw_req = 1'b1; #1;
        chk1("dup2_gnt", sw_gnt, 1'b1);
`ifdef PADCTRL_ATTR_SEQ_SHADOW_EN
        tick(); sw_req = 1'b0; #1;
        chk1("dup2_we", we, 1'b0);
        tick(); #1;
        chk1("dup2_busy", busy, 1'b0);
`else
        push(5'd5, 8'h12);
        tick(); sw_req = 1'b0; #1;
        chk1("dup2_we", we, 1'b1);
        chk1("dup2_busy", busy, 1'b1);
`endif
        wait_idle();

        // No settle window: back-to-back writes on alternate cycles.
        tick(); sw0_req = 1'b1; sw0_idx = 5'd0; sw0_attr = 8'h5A; #1;
        chk1("s0_gnt1", sw0_gnt, 1'b1);
        push0(5'd0, 8'h1A);
        tick(); sw0_idx = 5'd1; sw0_attr = 8'h66; #1;
        chk1("s0_we1", we0, 1'b1);
        chk1("s0_busy1", busy0, 1'b1);
        chk1("s0_no_gnt_apply", sw0_gnt, 1'b0);
        tick(); #1;
        chk1("s0_we_gap", we0, 1'b0);
        chk1("s0_busy_gap", busy0, 1'b0);
        chk1("s0_gnt2", sw0_gnt, 1'b1);
        push0(5'd1, 8'h26);
        tick(); sw0_req = 1'b0; #1;
        chk1("s0_we2", we0, 1'b1);
        chk("s0_idx2", 32'(attr0_idx), 32'd1);
        tick(); #1;
        chk1("s0_we_end", we0, 1'b0);
        chk("s0_attr_hold", 32'(attr0_val), 32'h26);

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("queue0_drained", 32'(exp0_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/padctrl_attr_seq.md
# padctrl_attr_seq

Pad-attribute update sequencer between the pad-attribute requesters and the pad controller's attribute register file. It arbitrates attribute writes from a software requester and a hardware requester (e.g. a power/sleep manager) round-robin and applies the WARL mask. It issues one pad write at a time, then enforces a settle window before the next write, so pad drive and pull changes never switch simultaneously.

## Interface

Parameters:
- NPads, 20: total pads addressed (16 MIO + 4 DIO; MIO indices 0-15, DIO 16-19).
- AttrDw, 8: attribute width.
- SettleCycles, 4: idle cycles enforced after each write; 0 legal.
- IdxW, $clog2(NPads): pad index width (5 at default).

Ports:
- clk_i  in  1  clock; all logic on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- sw_req_i  in  1  software write request; held until granted.
- sw_idx_i  in  IdxW  software target pad.
- sw_attr_i  in  AttrDw  software attribute value.
- sw_gnt_o  out  1  software grant, single-cycle.
- hw_req_i / hw_idx_i / hw_attr_i / hw_gnt_o: same widths and meanings for the hardware requester.
- warl_mask_i  in  AttrDw  implementation attribute mask (0x3F generic, 0x03 Xilinx).
- attr_we_o  out  1  single-cycle write strobe to the attribute register.
- attr_idx_o  out  IdxW  pad index of the write.
- attr_o  out  AttrDw  masked attribute value.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- err_o  out  1  single-cycle pulse on an out-of-range index.

## Operation

- FSM states: IDLE, APPLY, SETTLE.
- **IDLE**: if any request is high, the arbiter picks a winner and asserts its gnt combinationally that cycle.
  - The winner's idx and attr are captured.
  - Valid idx goes to APPLY.
  - idx ≥ NPads: pulse err_o next cycle, issue no write, stay in IDLE.
- **Arbitration**: round-robin with a last-grant pointer.
  - If only one requester is active, it wins.
  - If both are active, the one not granted last wins.
  - The pointer updates on every grant, including errored grants.
- **APPLY**: one cycle.
  - attr_we_o=1, attr_idx_o=captured idx, attr_o = captured attr & warl_mask_i (mask sampled in APPLY).
  - Next state: SETTLE if SettleCycles>0, else IDLE.
- **SETTLE**: down-counter loaded with SettleCycles-1 on entry; go to IDLE when it reaches 0. No grants are issued.
- gnt is never asserted outside IDLE. A requester dropping req before grant is legal; nothing is captured.
- attr_idx_o and attr_o hold their last value between writes; only attr_we_o qualifies them.

## Timing

- Reset values: sw_gnt_o, hw_gnt_o, attr_we_o, busy_o, err_o = 0; attr_idx_o, attr_o = 0.
  - FSM resets to IDLE, counter to 0.
  - Last-grant pointer resets to hw, so sw wins the first contention.
- Grant at cycle T → attr_we_o at T+1 → next grant earliest at T+2+SettleCycles.
- Errored grant at T → err_o at T+1 → next grant earliest at T+1.
- busy_o is a registered copy of (state≠IDLE).
- Reset asserted mid-APPLY or mid-SETTLE aborts immediately: no write strobe, pending captured request dropped.
- A request arriving in the same cycle the FSM returns to IDLE is granted that cycle.

## Configuration

- `PADCTRL_ATTR_SEQ_SHADOW_EN` defined:
  - Keeps an NPads×AttrDw shadow of the last written masked value per pad, reset 0.
  - A granted request whose masked attr equals the shadow produces no attr_we_o and no settle window; the FSM returns to IDLE the next cycle.
  - The shadow updates on every attr_we_o.
- Undefined: no shadow storage; every valid grant writes and settles.

## Test plan

- **Single sw write**: sw_req idx=3 attr=0xFF, mask=0x3F, SettleCycles=4.
  - sw_gnt at T; attr_we_o at T+1 with idx=3, attr_o=0x3F.
  - busy_o high T+1..T+5; next grant no earlier than T+6.
- **Contention fairness**: sw and hw requesting continuously from reset. Grants alternate sw, hw, sw, hw with spacing exactly 2+SettleCycles cycles.
- **Out of range**: hw_req idx=20. hw_gnt, then err_o pulse, no attr_we_o; next queued sw request granted the following cycle.
- **SettleCycles=0**: back-to-back sw requests, idx 0 and 1. Writes strobed on alternate cycles.
- **Reset mid-settle**: rst_ni low two cycles after a write. All outputs 0 immediately; first post-reset contention is granted to sw.
- **Shadow on** (macro defined): write idx=5 attr=0x12 twice. Second request granted with no attr_we_o and busy_o low one cycle later. Macro undefined: both requests write.
